// File: rtl/mvm_job_arbiter.sv
// Grants one of two requesters exclusive use of a matrix-vector engine,
// streams its K*K matrix and K vector words to the engine, and returns
// the K results. Optional round-robin tie breaking: MVM_ARB_ROUND_ROBIN_EN.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req0/1, gnt0/1        job request, one-hot grant held for the job
//   wvalid0/1, wdata0/1   requester word stream (matrix row-major, then vector)
//   rdata, rvalid, rlast  result stream back to the granted requester
//   busy, err             not idle; one-cycle pulse on engine timeout
//   mvm_*                 engine commands, input word, done, result stream
// OUT_LAT must be at least 1.
module mvm_job_arbiter #(
  parameter int K        = 16,
  parameter int B        = 8,
  parameter int OUT_LAT  = 2,
  parameter int WAIT_MAX = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wvalid0,
  input  logic                  wvalid1,
  input  logic signed [B-1:0]   wdata0,
  input  logic signed [B-1:0]   wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic signed [2*B-1:0] rdata,
  output logic                  rvalid,
  output logic                  rlast,
  output logic                  busy,
  output logic                  err,
  output logic                  mvm_loadMatrix,
  output logic                  mvm_loadVector,
  output logic                  mvm_start,
  output logic signed [B-1:0]   mvm_data_in,
  input  logic                  mvm_done,
  input  logic signed [2*B-1:0] mvm_data_out
);

  localparam int NA = K * K;
  localparam int CW = $clog2(NA + 1);
  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam int DW = $clog2(OUT_LAT + K + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_X, S_START,
    S_WAIT, S_DRAIN, S_RELEASE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dcnt;

  logic                wv;
  logic signed [B-1:0] wd;
  logic                any_req;
  logic                pick1;
  logic                a_last;
  logic                x_last;
  logic                timeout;
  logic                cap;
  logic                d_last;

  // Only the granted side is ever observed.
  assign wv = gnt1 ? wvalid1 : (gnt0 & wvalid0);
  assign wd = gnt1 ? wdata1 : wdata0;
  assign any_req = req0 | req1;

`ifdef MVM_ARB_ROUND_ROBIN_EN
  logic ptr;
  assign pick1 = req1 & (~req0 | ptr);
`else
  assign pick1 = req1 & ~req0;
`endif

  assign a_last  = (state == S_LOAD_A) && wv && (cnt == CW'(NA - 1));
  assign x_last  = (state == S_LOAD_X) && wv && (cnt == CW'(K - 1));
  assign timeout = (state == S_WAIT) && !mvm_done
                && (tcnt == TW'(WAIT_MAX - 1));
  // dcnt is 1 in the first DRAIN cycle, i.e. the cycle after mvm_done.
  assign cap     = (state == S_DRAIN) && (dcnt >= DW'(OUT_LAT))
                && (dcnt < DW'(OUT_LAT + K));
  assign d_last  = (state == S_DRAIN)
                && (dcnt == DW'(OUT_LAT + K - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (any_req) nxt = S_LOAD_A;
      S_LOAD_A:  if (a_last) nxt = S_LOAD_X;
      S_LOAD_X:  if (x_last) nxt = S_START;
      S_START:   nxt = S_WAIT;
      S_WAIT: begin
        if (mvm_done)     nxt = S_DRAIN;
        else if (timeout) nxt = S_RELEASE;
      end
      S_DRAIN:   if (d_last) nxt = S_RELEASE;
      S_RELEASE: nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != S_IDLE);
    err            = timeout;
    mvm_loadMatrix = (state == S_LOAD_A) && wv && (cnt == '0);
    mvm_loadVector = (state == S_LOAD_X) && wv && (cnt == '0);
    mvm_start      = (state == S_START);
  end

  // A bubble inside a load phase restarts it; the engine cannot stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == S_LOAD_A || state == S_LOAD_X) begin
      if (!wv || a_last || x_last) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tcnt <= '0;
    else if (state == S_WAIT) tcnt <= tcnt + TW'(1);
    else                      tcnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            dcnt <= '0;
    else if (state == S_WAIT && mvm_done) dcnt <= DW'(1);
    else if (state == S_DRAIN)            dcnt <= dcnt + DW'(1);
    else                                  dcnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      gnt0 <= ~pick1;
      gnt1 <= pick1;
    end else if (state == S_RELEASE) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end
  end

`ifdef MVM_ARB_ROUND_ROBIN_EN
  // Point at whoever was not served by the job now ending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   ptr <= 1'b0;
    else if (state == S_RELEASE) ptr <= gnt0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             mvm_data_in <= '0;
    else if (gnt0 | gnt1)  mvm_data_in <= wd;
    else                   mvm_data_in <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end else begin
      rvalid <= cap;
      rlast  <= cap && d_last;
      if (cap) rdata <= mvm_data_out;
    end
  end

endmodule

// File: tb/tb_mvm_job_arbiter.sv
// Self-checking bench for mvm_job_arbiter with K=2, B=8, OUT_LAT=2.
// Contains a small behavioural engine and a per-cycle result checker.
module tb_mvm_job_arbiter;

  localparam int K  = 2;
  localparam int B  = 8;
  localparam int OL = 2;
  localparam int WM = 40;
  localparam int NA = K * K;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, wvalid0, wvalid1;
  logic signed [B-1:0]   wdata0, wdata1;
  logic gnt0, gnt1, rvalid, rlast, busy, err;
  logic signed [2*B-1:0] rdata;
  logic lm, lv, st;
  logic signed [B-1:0]   mdin;
  logic mvm_done;
  logic signed [2*B-1:0] mvm_data_out;

  mvm_job_arbiter #(.K(K), .B(B), .OUT_LAT(OL), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(rst),
    .req0(req0), .req1(req1),
    .wvalid0(wvalid0), .wvalid1(wvalid1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .busy(busy), .err(err),
    .mvm_loadMatrix(lm), .mvm_loadVector(lv), .mvm_start(st),
    .mvm_data_in(mdin),
    .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
  );

  always #5 clk = ~clk;

  int nc = 0;
  int nm = 0;

  task automatic chk(input string nm_s, input int act, input int exp_v);
    nc++;
    if (act != exp_v) begin
      nm++;
      $display("FAIL %s: got %0d expected %0d", nm_s, act, exp_v);
    end
  endtask

  // Model state
  int mat[NA];
  int vec[K];
  logic signed [15:0] ey[K];
  int ptr = 0;
  bit mute = 0;
  int got[$];

  // Engine and checker state
  int cyc = 0;
  int emode = 0, eidx = 0;
  int ea[NA];
  int ex[K];
  logic signed [15:0] eyy[K];
  int s_cyc = -1000, d_cyc = -1000, e_cyc = -1000, stray = -1000;
  int n_lm = 0, n_lv = 0, n_st = 0;
  logic nd_done = 1'b0;
  logic signed [15:0] nd_data = 16'sh5A5A;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    mvm_done     = nd_done;
    mvm_data_out = nd_data;
  end

  always @(negedge clk) begin
    int rr;
    int s;
    if (rst) begin
      emode = 0; d_cyc = -1000; s_cyc = -1000; e_cyc = -1000;
      nd_done = 1'b0; nd_data = 16'sh5A5A;
    end else begin
      // engine: capture words that follow a load pulse
      if (emode == 1) begin
        ea[eidx] = int'(mdin); eidx++;
        if (eidx == NA) emode = 0;
      end else if (emode == 2) begin
        ex[eidx] = int'(mdin); eidx++;
        if (eidx == K) emode = 0;
      end
      if (lm) begin emode = 1; eidx = 0; n_lm++; end
      if (lv) begin emode = 2; eidx = 0; n_lv++; end
      if (st) begin
        n_st++;
        s_cyc = cyc;
        for (int r = 0; r < K; r++) begin
          s = 0;
          for (int c = 0; c < K; c++) s += ea[r*K+c] * ex[c];
          eyy[r] = s[15:0];
        end
        if (!mute) d_cyc = cyc + 3;
      end
      nd_done = (cyc + 1 == d_cyc) || (cyc + 1 == stray);
      rr = cyc + 1 - d_cyc - OL;
      nd_data = (rr >= 0 && rr < K) ? eyy[rr] : 16'sh5A5A;

      // checker
      rr = cyc - d_cyc - OL - 1;
      chk("rvalid", int'(rvalid), int'(rr >= 0 && rr < K));
      if (rr >= 0 && rr < K) begin
        chk("rdata", int'(rdata), int'(ey[rr]));
        chk("rlast", int'(rlast), int'(rr == K - 1));
      end
      if (rvalid) got.push_back(int'(rdata));
      chk("err", int'(err), int'(mute && s_cyc >= 0 && cyc == s_cyc + WM));
      if (err) e_cyc = cyc;
      if (cyc == e_cyc + 1) chk("busy_after_err1", int'(busy), 1);
      if (cyc == e_cyc + 2) chk("busy_after_err2", int'(busy), 0);
      chk("cmd_excl", int'($countones({lm, lv, st}) <= 1), 1);
      chk("gnt_excl", int'(!(gnt0 && gnt1)), 1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"}, int'(gnt0), 0);
    chk({tag, "_gnt1"}, int'(gnt1), 0);
    chk({tag, "_rvalid"}, int'(rvalid), 0);
    chk({tag, "_rlast"}, int'(rlast), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_cmds"}, int'({lm, lv, st}), 0);
    chk({tag, "_din"}, int'(mdin), 0);
  endtask

  task automatic set_model;
    int s;
    for (int r = 0; r < K; r++) begin
      s = 0;
      for (int c = 0; c < K; c++) s += mat[r*K+c] * vec[c];
      ey[r] = s[15:0];
    end
  endtask

  task automatic drive(input int g, input int v, input bit on);
    int nv;
    nv = ~v;
    if (g == 0) begin
      wvalid0 = on; wdata0 = v[7:0];
      wvalid1 = 1'b1; wdata1 = nv[7:0];
    end else begin
      wvalid1 = on; wdata1 = v[7:0];
      wvalid0 = 1'b1; wdata0 = nv[7:0];
    end
  endtask

  task automatic job(input bit r0, input bit r1, input int gap,
                     input bit m, input bit do_stray);
    int eg, t, gg;
    int wq[$];
    eg = (r0 && r1) ? ptr : (r1 ? 1 : 0);
    set_model();
    mute = m;
    n_lm = 0; n_lv = 0; n_st = 0;
    got.delete();
    if (do_stray) stray = cyc + 3;
    req0 = r0; req1 = r1;
    tick();
    t = 0;
    while (!(gnt0 || gnt1) && t < 20) begin tick(); t++; end
    chk("grant_seen", int'(gnt0 || gnt1), 1);
    gg = gnt1 ? 1 : 0;
    chk("grant_who", gg, eg);
    req0 = 0; req1 = 0;
    if (gap >= 0) begin
      for (int i = 0; i < gap; i++) wq.push_back(mat[i]);
      wq.push_back(1000);
    end
    for (int i = 0; i < NA; i++) wq.push_back(mat[i]);
    for (int i = 0; i < K; i++) wq.push_back(vec[i]);
    foreach (wq[i]) begin
      drive(eg, wq[i] == 1000 ? 0 : wq[i], wq[i] != 1000);
      tick();
    end
    wvalid0 = 0; wvalid1 = 0;
    t = 0;
    while (busy && t < WM + 100) begin tick(); t++; end
    chk("job_end", int'(busy), 0);
    chk("n_loadMatrix", n_lm, gap >= 0 ? 2 : 1);
    chk("n_loadVector", n_lv, 1);
    chk("n_start", n_st, 1);
    chk("gnt_after", int'({gnt0, gnt1}), 0);
    chk("n_results", got.size(), m ? 0 : K);
`ifdef MVM_ARB_ROUND_ROBIN_EN
    ptr = 1 - eg;
`endif
    stray = -1000;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1;
    req0 = 0; req1 = 0; wvalid0 = 0; wvalid1 = 0;
    wdata0 = 0; wdata1 = 0;
    #3;
    chk_zero("reset");
    tick(); tick();
    rst = 0;
    tick();

    // basic job
    mat = '{1, 2, 3, 4}; vec = '{5, 6};
    job(1, 0, -1, 0, 0);
    chk("lit_y0", got.size() > 0 ? got[0] : -1, 17);
    chk("lit_y1", got.size() > 1 ? got[1] : -1, 39);

    // two ties
    mat = '{1, 0, 0, 1}; vec = '{9, -4};
    job(1, 1, -1, 0, 0);
    mat = '{-2, 3, 1, 1}; vec = '{4, 5};
    job(1, 1, -1, 0, 0);

    // bubble after word 2, full reload, stray done during load
    mat = '{2, -3, 4, 5}; vec = '{7, -1};
    job(1, 0, 2, 0, 1);
    chk("lit_gap_y0", got.size() > 0 ? got[0] : -1, 17);
    chk("lit_gap_y1", got.size() > 1 ? got[1] : -1, 23);

    // engine never finishes
    mat = '{1, 1, 1, 1}; vec = '{1, 1};
    job(0, 1, -1, 1, 0);
    mute = 0;

    // reset during LOAD_X
    mat = '{3, 3, 3, 3}; vec = '{1, 2};
    req0 = 1;
    tick();
    t = 0;
    while (!gnt0 && t < 20) begin tick(); t++; end
    chk("rst_job_gnt", int'(gnt0), 1);
    req0 = 0;
    for (int i = 0; i < NA; i++) begin drive(0, mat[i], 1); tick(); end
    drive(0, vec[0], 1);
    tick();
    #2 rst = 1;
    wvalid0 = 0; wvalid1 = 0;
    #1 chk_zero("midreset");
    tick(); tick();
    rst = 0;
    ptr = 0;
    tick();
    mat = '{-1, 2, 3, -4}; vec = '{10, 20};
    job(0, 1, -1, 0, 0);
    chk("lit_rst_y0", got.size() > 0 ? got[0] : -1, 30);
    chk("lit_rst_y1", got.size() > 1 ? got[1] : -1, -50);

    // overflow wraps to 16 bits
    mat = '{-128, -128, -128, -128}; vec = '{-128, -128};
    job(1, 0, -1, 0, 0);
    chk("lit_ovf_y0", got.size() > 0 ? got[0] : 0, -32768);
    chk("lit_ovf_y1", got.size() > 1 ? got[1] : 0, -32768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end

endmodule
